// File: rtl/npu_seq_ctrl_pkg.sv
// Shared definitions for the NPU sequencer: state encodings, result byte
// count and the clamp bounds used when NPU_OUT_SAT_EN is defined.
package npu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_RELU    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

  // Number of bytes in one channel result.
  function automatic int bytes_per_res(input int acc_w);
    return acc_w / 8;
  endfunction

  // Clamp bounds for a signed result squeezed into an unsigned byte.
  localparam logic [7:0] SAT_LO = 8'h00;
  localparam logic [7:0] SAT_HI = 8'hFF;

endpackage

// File: rtl/npu_seq_ctrl_if.sv
// Host/datapath signal bundle of the NPU sequencer. The master modport is
// the controller's view; the slave modport is the surrounding NPU/host.
interface npu_seq_ctrl_if #(
  parameter int NUM_CH    = 2,
  parameter int ACC_W     = 16,
  parameter int ACC_LEN_W = 8,
  parameter int VEC_W     = 8
);
  logic                    START;
  logic                    ABORT;
  logic [ACC_LEN_W-1:0]    ACC_LEN;
  logic [VEC_W-1:0]        NUM_VEC;
  logic                    CFG_BYPASS_RELU;
  logic [NUM_CH*ACC_W-1:0] RELU_Y;
  logic                    FIFO_FULL;
  logic                    EN_BUF_IN;
  logic                    EN_MAC;
  logic                    RST_MAC;
  logic                    EN_RELU;
  logic                    BYPASS_RELU;
  logic                    FIFO_WR_EN;
  logic [7:0]              FIFO_WDATA;
  logic                    BUSY;
  logic                    DONE;

  modport master (
    input  START, ABORT, ACC_LEN, NUM_VEC, CFG_BYPASS_RELU, RELU_Y, FIFO_FULL,
    output EN_BUF_IN, EN_MAC, RST_MAC, EN_RELU, BYPASS_RELU,
           FIFO_WR_EN, FIFO_WDATA, BUSY, DONE
  );

  modport slave (
    output START, ABORT, ACC_LEN, NUM_VEC, CFG_BYPASS_RELU, RELU_Y, FIFO_FULL,
    input  EN_BUF_IN, EN_MAC, RST_MAC, EN_RELU, BYPASS_RELU,
           FIFO_WR_EN, FIFO_WDATA, BUSY, DONE
  );
endinterface

// File: rtl/npu_byte_serializer.sv
// Captures the ReLU outputs and streams them into the output FIFO one byte
// per write, channel 0 first, MSB byte first, stalling while the FIFO is full.
// Build option NPU_OUT_SAT_EN: clamp each signed result to one unsigned byte.
module npu_byte_serializer
  import npu_seq_ctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 16
) (
  input  logic                    CLKEXT,
  input  logic                    RST_GLO,
  input  logic                    i_start,
  input  logic                    i_in_write,
  input  logic                    i_abort,
  input  logic                    i_fifo_full,
  input  logic [NUM_CH*ACC_W-1:0] i_relu_y,
  output logic                    o_wr_en,
  output logic [7:0]              o_wdata,
  output logic                    o_last
);
  localparam int BPR = bytes_per_res(ACC_W);
`ifdef NPU_OUT_SAT_EN
  localparam int BYTES_OUT = 1;
`else
  localparam int BYTES_OUT = BPR;
`endif
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BI_W = (BYTES_OUT > 1) ? $clog2(BYTES_OUT) : 1;
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES_OUT - 1);

  logic [NUM_CH*ACC_W-1:0] r_res;
  logic [CH_W-1:0]         r_ch_idx;
  logic [BI_W-1:0]         r_byte_idx;
  logic [7:0]              w_byte [NUM_CH][BYTES_OUT];

  // Per-channel byte table: either the raw result bytes or one clamped byte.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ACC_W-1:0] w_word;
      assign w_word = r_res[gi*ACC_W +: ACC_W];
`ifdef NPU_OUT_SAT_EN
      logic w_big;
      if (ACC_W > 8) begin : g_wide
        assign w_big = |w_word[ACC_W-1:8];
      end else begin : g_narrow
        assign w_big = 1'b0;
      end
      // Sign bit wins first, so w_big only matters for non-negative values.
      assign w_byte[gi][0] = w_word[ACC_W-1] ? SAT_LO :
                             (w_big ? SAT_HI : w_word[7:0]);
`else
      for (genvar gj = 0; gj < BPR; gj++) begin : g_byte
        assign w_byte[gi][gj] = w_word[(BPR-1-gj)*8 +: 8];
      end
`endif
    end
  endgenerate

  assign o_wr_en = i_in_write & ~i_fifo_full & ~i_abort;
  assign o_wdata = i_in_write ? w_byte[r_ch_idx][r_byte_idx] : 8'h00;
  assign o_last  = o_wr_en & (r_ch_idx == LAST_CH) & (r_byte_idx == LAST_BYTE);

  // Capture on ReLU exit; step byte then channel only when a write happens.
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      r_res      <= '0;
      r_ch_idx   <= '0;
      r_byte_idx <= '0;
    end else if (i_start) begin
      r_res      <= i_relu_y;
      r_ch_idx   <= '0;
      r_byte_idx <= '0;
    end else if (o_wr_en) begin
      if (r_byte_idx == LAST_BYTE) begin
        r_byte_idx <= '0;
        r_ch_idx   <= (r_ch_idx == LAST_CH) ? '0 : r_ch_idx + 1'b1;
      end else begin
        r_byte_idx <= r_byte_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/npu_seq_ctrl.sv
// NPU datapath sequencer: per vector load, accumulate, ReLU and serialise the
// results into the output FIFO; repeats NUM_VEC times per START, abortable.
// Build option NPU_OUT_SAT_EN: one clamped byte per channel instead of all.
module npu_seq_ctrl
  import npu_seq_ctrl_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ACC_W     = 16,
  parameter int ACC_LEN_W = 8,
  parameter int VEC_W     = 8
) (
  input  logic          CLKEXT,
  input  logic          RST_GLO,
  npu_seq_ctrl_if.master bus
);
  state_t               r_state, w_state_next;
  logic [ACC_LEN_W-1:0] r_acc_len;
  logic [ACC_LEN_W-1:0] r_cyc_cnt, w_cyc_cnt_next;
  logic [VEC_W-1:0]     r_num_vec;
  logic [VEC_W-1:0]     r_vec_cnt, w_vec_cnt_next;
  logic                 r_bypass;
  logic                 w_in_write;
  logic                 w_ser_start;
  logic                 w_wr_en;
  logic                 w_last_wr;
  logic [7:0]           w_wdata;

  assign w_in_write  = (r_state == ST_WRITE);
  assign w_ser_start = (r_state == ST_RELU);

  // Latch the run configuration when a START is accepted; zero means one.
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      r_acc_len <= '0;
      r_num_vec <= '0;
      r_bypass  <= 1'b0;
    end else if (r_state == ST_IDLE && bus.START) begin
      r_acc_len <= (bus.ACC_LEN == '0) ? ACC_LEN_W'(1) : bus.ACC_LEN;
      r_num_vec <= (bus.NUM_VEC == '0) ? VEC_W'(1) : bus.NUM_VEC;
      r_bypass  <= bus.CFG_BYPASS_RELU;
    end
  end

  // State and counter registers.
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      r_state   <= ST_IDLE;
      r_cyc_cnt <= '0;
      r_vec_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cyc_cnt <= w_cyc_cnt_next;
      r_vec_cnt <= w_vec_cnt_next;
    end
  end

  // Next-state logic; ABORT overrides every transition out of a busy state.
  always_comb begin
    w_state_next   = r_state;
    w_cyc_cnt_next = r_cyc_cnt;
    w_vec_cnt_next = r_vec_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.START) begin
          w_state_next   = ST_LOAD;
          w_vec_cnt_next = '0;
          w_cyc_cnt_next = '0;
        end
      end
      ST_LOAD: begin
        w_state_next   = ST_COMPUTE;
        w_cyc_cnt_next = '0;
      end
      ST_COMPUTE: begin
        if (r_cyc_cnt == r_acc_len - 1'b1) begin
          w_state_next = ST_RELU;
        end else begin
          w_cyc_cnt_next = r_cyc_cnt + 1'b1;
        end
      end
      ST_RELU: begin
        w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (w_last_wr) begin
          if (r_vec_cnt == r_num_vec - 1'b1) begin
            w_state_next = ST_FINISH;
          end else begin
            w_vec_cnt_next = r_vec_cnt + 1'b1;
            w_state_next   = ST_LOAD;
          end
        end
      end
      ST_FINISH: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (bus.ABORT && r_state != ST_IDLE) begin
      w_state_next = ST_IDLE;
    end
  end

  npu_byte_serializer #(
    .NUM_CH (NUM_CH),
    .ACC_W  (ACC_W)
  ) u_ser (
    .CLKEXT      (CLKEXT),
    .RST_GLO     (RST_GLO),
    .i_start     (w_ser_start),
    .i_in_write  (w_in_write),
    .i_abort     (bus.ABORT),
    .i_fifo_full (bus.FIFO_FULL),
    .i_relu_y    (bus.RELU_Y),
    .o_wr_en     (w_wr_en),
    .o_wdata     (w_wdata),
    .o_last      (w_last_wr)
  );

  // Datapath strobes decode the registered state; abort suppresses the
  // write strobe and the completion pulse in the same cycle.
  assign bus.EN_BUF_IN   = (r_state == ST_LOAD);
  assign bus.RST_MAC     = (r_state == ST_LOAD);
  assign bus.EN_MAC      = (r_state == ST_COMPUTE);
  assign bus.EN_RELU     = (r_state == ST_RELU);
  assign bus.BUSY        = (r_state != ST_IDLE);
  assign bus.BYPASS_RELU = (r_state != ST_IDLE) & r_bypass;
  assign bus.DONE        = (r_state == ST_FINISH) & ~bus.ABORT;
  assign bus.FIFO_WR_EN  = w_wr_en;
  assign bus.FIFO_WDATA  = w_wdata;

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Scoreboard bench for npu_seq_ctrl: a timeline model predicts per-cycle
// strobes and the FIFO write stream; a negedge monitor compares.
module tb_npu_seq_ctrl;
  localparam int NUM_CH    = 2;
  localparam int ACC_W     = 16;
  localparam int ACC_LEN_W = 8;
  localparam int VEC_W     = 8;
  localparam int BPR       = ACC_W / 8;
  localparam int MAXT      = 300;

  logic CLKEXT  = 1'b0;
  logic RST_GLO = 1'b1;
  always #5 CLKEXT = ~CLKEXT;

  npu_seq_ctrl_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .ACC_LEN_W(ACC_LEN_W), .VEC_W(VEC_W)) bus ();

  npu_seq_ctrl #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .ACC_LEN_W(ACC_LEN_W), .VEC_W(VEC_W)) dut (
    .CLKEXT  (CLKEXT),
    .RST_GLO (RST_GLO),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cyc = 0;
  int run_id = 0;
  bit mon_on = 1'b0;

  bit e_busy[MAXT], e_buf[MAXT], e_mac[MAXT], e_relu[MAXT], e_done[MAXT];
  bit e_wr[MAXT], e_wdc[MAXT], full_pat[MAXT];
  logic [7:0] e_wd[MAXT];
  bit e_byp;

  typedef struct {int t; logic [7:0] d;} wr_t;
  wr_t exp_q[$];

  always @(posedge CLKEXT) cyc <= cyc + 1;

  function automatic void check(string name, int t, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s run=%0d t=%0d got=%0h expected=%0h", name, run_id, t, act, exp);
    end
  endfunction

  // Monitor: per-cycle strobe checks and write-stream scoreboard.
  always @(negedge CLKEXT) begin : mon
    int t;
    wr_t e;
    if (mon_on) begin
      t = cyc - start_cyc;
      if (t >= 0 && t < MAXT) begin
        check("BUSY", t, bus.BUSY, e_busy[t]);
        check("EN_BUF_IN", t, bus.EN_BUF_IN, e_buf[t]);
        check("RST_MAC", t, bus.RST_MAC, e_buf[t]);
        check("EN_MAC", t, bus.EN_MAC, e_mac[t]);
        check("EN_RELU", t, bus.EN_RELU, e_relu[t]);
        check("DONE", t, bus.DONE, e_done[t]);
        check("BYPASS", t, bus.BYPASS_RELU, e_busy[t] & e_byp);
        if (e_wdc[t]) check("WDATA", t, bus.FIFO_WDATA, e_wd[t]);
        else if (!e_busy[t]) check("WDATA_IDLE", t, bus.FIFO_WDATA, 0);
        if (bus.FIFO_WR_EN) begin
          if (exp_q.size() == 0) begin
            check("WR_UNEXPECTED", t, exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("WR_TIME", t, t, e.t);
            check("WR_DATA", t, bus.FIFO_WDATA, e.d);
            $display("[TB] run %0d write t=%0d data=%02h", run_id, t, bus.FIFO_WDATA);
          end
        end
      end
    end
  end

  // Build the expected timeline for one run, then drive it cycle by cycle.
  task automatic run_test(input int acc_in, input int nv_in, input bit byp,
                          input logic [NUM_CH*ACC_W-1:0] relu,
                          input int ta, input int ts, input int tr);
    int acc, nv, t, done_t, last, t_end;
    logic [7:0] bl[$];
    logic [ACC_W-1:0] w;
    int sv;
    wr_t e;
    acc = (acc_in == 0) ? 1 : acc_in;
    nv  = (nv_in == 0) ? 1 : nv_in;
    for (int c = 0; c < NUM_CH; c++) begin
      w = relu[c*ACC_W +: ACC_W];
`ifdef NPU_OUT_SAT_EN
      sv = $signed(w);
      bl.push_back(sv < 0 ? 8'h00 : (sv > 255 ? 8'hFF : 8'(sv)));
`else
      sv = 0;
      for (int b = 0; b < BPR; b++) bl.push_back(8'((w >> (8 * (BPR - 1 - b))) & 'hFF));
`endif
    end
    for (int i = 0; i < MAXT; i++) begin
      e_busy[i] = 0; e_buf[i] = 0; e_mac[i] = 0; e_relu[i] = 0;
      e_done[i] = 0; e_wr[i] = 0; e_wdc[i] = 0; e_wd[i] = 8'h00;
    end
    t = 0;
    for (int v = 0; v < nv; v++) begin
      e_buf[t] = 1; t++;
      for (int c = 0; c < acc; c++) begin e_mac[t] = 1; t++; end
      e_relu[t] = 1; t++;
      foreach (bl[b]) begin
        while (full_pat[t]) begin e_wdc[t] = 1; e_wd[t] = bl[b]; t++; end
        e_wr[t] = 1; e_wdc[t] = 1; e_wd[t] = bl[b]; t++;
      end
    end
    done_t = t;
    e_done[done_t] = 1;
    for (int i = 0; i <= done_t; i++) e_busy[i] = 1;
    last = done_t;
    if (ta >= 0 && ta <= done_t) begin
      e_wr[ta] = 0; e_done[ta] = 0; last = ta;
      for (int i = ta + 1; i < MAXT; i++) begin
        e_busy[i] = 0; e_buf[i] = 0; e_mac[i] = 0; e_relu[i] = 0;
        e_done[i] = 0; e_wr[i] = 0; e_wdc[i] = 0;
      end
    end
    if (tr >= 0) begin
      last = tr - 1;
      for (int i = tr; i < MAXT; i++) begin
        e_busy[i] = 0; e_buf[i] = 0; e_mac[i] = 0; e_relu[i] = 0;
        e_done[i] = 0; e_wr[i] = 0; e_wdc[i] = 0;
      end
    end
    t_end = last + 3;
    if (tr >= 0 && t_end < tr + 4) t_end = tr + 4;
    exp_q.delete();
    for (int i = 0; i < MAXT; i++) if (e_wr[i]) begin e.t = i; e.d = e_wd[i]; exp_q.push_back(e); end
    e_byp = byp;
    run_id++;

    @(posedge CLKEXT); #1;
    bus.ACC_LEN = ACC_LEN_W'(acc_in);
    bus.NUM_VEC = VEC_W'(nv_in);
    bus.CFG_BYPASS_RELU = byp;
    bus.RELU_Y = relu;
    bus.START = 1'b1;
    @(posedge CLKEXT); #1;
    start_cyc = cyc;
    mon_on = 1'b1;
    for (int k = 0; k <= t_end; k++) begin
      bus.START = (k == ts);
      bus.ABORT = (k == ta);
      bus.FIFO_FULL = full_pat[k];
      bus.ACC_LEN = ACC_LEN_W'($urandom);
      bus.NUM_VEC = VEC_W'($urandom);
      bus.CFG_BYPASS_RELU = 1'($urandom);
      if (k == tr) begin
        RST_GLO = 1'b1;
        #1;
        check("RST_ASYNC_BUSY", k, bus.BUSY, 0);
        check("RST_ASYNC_WR_EN", k, bus.FIFO_WR_EN, 0);
        check("RST_ASYNC_WDATA", k, bus.FIFO_WDATA, 0);
        check("RST_ASYNC_BYPASS", k, bus.BYPASS_RELU, 0);
      end
      if (k == tr + 2) RST_GLO = 1'b0;
      @(posedge CLKEXT); #1;
    end
    mon_on = 1'b0;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    bus.FIFO_FULL = 1'b0;
    check("WR_MISSING", t_end, exp_q.size(), 0);
    $display("[TB] run %0d acc=%0d nv=%0d byp=%0d abort=%0d start_busy=%0d rst=%0d done_t=%0d",
             run_id, acc_in, nv_in, byp, ta, ts, tr, done_t);
    exp_q.delete();
  endtask

  task automatic clear_pat();
    for (int i = 0; i < MAXT; i++) full_pat[i] = 1'b0;
  endtask

  initial begin
    int ta, ts;
    logic [NUM_CH*ACC_W-1:0] r;
    bus.START = 0; bus.ABORT = 0; bus.ACC_LEN = '0; bus.NUM_VEC = '0;
    bus.CFG_BYPASS_RELU = 0; bus.RELU_Y = '0; bus.FIFO_FULL = 0;
    clear_pat();
    repeat (3) @(posedge CLKEXT);
    #1;
    check("RESET_BUSY", 0, bus.BUSY, 0);
    check("RESET_DONE", 0, bus.DONE, 0);
    check("RESET_WR_EN", 0, bus.FIFO_WR_EN, 0);
    check("RESET_WDATA", 0, bus.FIFO_WDATA, 0);
    check("RESET_EN_MAC", 0, bus.EN_MAC, 0);
    check("RESET_EN_BUF_IN", 0, bus.EN_BUF_IN, 0);
    RST_GLO = 1'b0;

    // Basic run: writes 12,34,AB,CD with no stalls.
    run_test(4, 1, 0, {16'hABCD, 16'h1234}, -1, -1, -1);
    // Backpressure while 0x34 is presented.
    full_pat[7] = 1; full_pat[8] = 1; full_pat[9] = 1;
    run_test(4, 1, 1, {16'hABCD, 16'h1234}, -1, -1, -1);
    clear_pat();
    // Multi-vector with zero config values.
    run_test(0, 3, 1, {16'h5A6B, 16'hF00D}, -1, -1, -1);
    // Abort in the second COMPUTE cycle, START while busy.
    run_test(4, 1, 0, {16'hABCD, 16'h1234}, 2, 1, -1);
    run_test(2, 2, 0, {16'h0102, 16'h0304}, -1, 3, -1);
    // Reset mid-WRITE, then a fresh run.
    run_test(4, 1, 1, {16'hABCD, 16'h1234}, -1, -1, 7);
    run_test(4, 1, 0, {16'hABCD, 16'h1234}, -1, -1, -1);
`ifdef NPU_OUT_SAT_EN
    // Clamp: 0x0123 -> FF, 0x8000 -> 00.
    run_test(4, 1, 0, {16'h8000, 16'h0123}, -1, -1, -1);
`endif
    // Randomised runs with random backpressure, aborts and busy STARTs.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < MAXT; i++) full_pat[i] = (i < 120) && ($urandom_range(0, 9) < 3);
      r = {$urandom, $urandom};
      ta = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      ts = ($urandom_range(0, 1) == 0) ? ((ta >= 0) ? $urandom_range(0, ta) : $urandom_range(0, 4)) : -1;
      run_test($urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom), r, ta, ts, -1);
    end
    clear_pat();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
